// File: rtl/loop_filter_pkg.sv
// Shared definitions for the bang-bang loop filter.
//   - err_t / ERR_*  : per-cycle phase-detector error encoding (+1, -1, 0)
//   - GUARD_BITS     : headroom added to the control word width for internal sums
//   - calc_width()   : internal signed arithmetic width for a given control word width
//   - sat_clamp()    : signed saturating clamp on a wide value
package loop_filter_pkg;

    typedef logic signed [1:0] err_t;

    localparam err_t ERR_POS  = 2'sb01;
    localparam err_t ERR_NEG  = 2'sb11;
    localparam err_t ERR_ZERO = 2'sb00;

    localparam int unsigned GUARD_BITS = 16;
    localparam int unsigned CLAMP_W    = 64;

    function automatic int unsigned calc_width(input int unsigned bc);
        return bc + GUARD_BITS;
    endfunction

    function automatic logic signed [CLAMP_W-1:0] sat_clamp(
        input logic signed [CLAMP_W-1:0] v,
        input logic signed [CLAMP_W-1:0] lo,
        input logic signed [CLAMP_W-1:0] hi
    );
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/bbpd_window_acc.sv
// Decimating vote accumulator for the bang-bang phase detector.
// Ports:
//   sys_clk    in   clock
//   ext_rst    in   synchronous active-high reset
//   up_pulse   in   +1 vote
//   dn_pulse   in   -1 vote
//   hold       in   clears the window and keeps it from ending
//   ws         out  window sum including the current cycle's vote
//   window_end out  high on the last cycle of a window (never while held)
module bbpd_window_acc
    import loop_filter_pkg::*;
#(
    parameter int unsigned decim = 16,
    parameter int unsigned acc_w = $clog2(decim) + 2
) (
    input  logic                    sys_clk,
    input  logic                    ext_rst,
    input  logic                    up_pulse,
    input  logic                    dn_pulse,
    input  logic                    hold,
    output logic signed [acc_w-1:0] ws,
    output logic                    window_end
);

    localparam int unsigned WCNT_W = $clog2(decim);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(decim - 1);

    err_t                    err;
    logic [WCNT_W-1:0]       wcnt_q;
    logic signed [acc_w-1:0] acc_q;

    always_comb begin
        err = ERR_ZERO;
        case ({up_pulse, dn_pulse})
            2'b10:   err = ERR_POS;
            2'b01:   err = ERR_NEG;
            default: err = ERR_ZERO;
        endcase
    end

    assign window_end = (wcnt_q == WCNT_LAST) && !hold;
    // Sum includes this cycle's vote so the last vote lands on the same edge.
    assign ws = acc_q + {{(acc_w - 2){err[1]}}, err};

    always_ff @(posedge sys_clk) begin
        if (ext_rst || hold || window_end) begin
            wcnt_q <= '0;
            acc_q  <= '0;
        end else begin
            wcnt_q <= wcnt_q + WCNT_W'(1);
            acc_q  <= ws;
        end
    end

endmodule

// File: rtl/pi_loop_filter.sv
// PI loop filter between the bang-bang phase detector and the DCO/NCO control word.
// Ports:
//   sys_clk       in   clock
//   ext_rst       in   synchronous active-high reset (overrides hold)
//   up_pulse      in   +1 phase vote
//   dn_pulse      in   -1 phase vote
//   hold          in   freeze integrator/output, restart the window
//   speed_var     out  registered control word
//   update_strobe out  high in the cycle speed_var shows a new value
//   locked        out  lock indication
module pi_loop_filter
    import loop_filter_pkg::*;
#(
    parameter int unsigned bit_count     = 24,
    parameter int unsigned default_speed = 8388608,
    parameter int unsigned max_speed     = 16777215,
    parameter int unsigned min_speed     = 0,
    parameter int unsigned kp            = 256,
    parameter int unsigned ki            = 1,
    parameter int unsigned decim         = 16,
    parameter int unsigned lock_thresh   = 2,
    parameter int unsigned lock_count    = 8
) (
    input  logic                 sys_clk,
    input  logic                 ext_rst,
    input  logic                 up_pulse,
    input  logic                 dn_pulse,
    input  logic                 hold,
    output logic [bit_count-1:0] speed_var,
    output logic                 update_strobe,
    output logic                 locked
);

    localparam int unsigned W   = calc_width(bit_count);
    localparam int unsigned AW  = $clog2(decim) + 2;
    localparam int unsigned LRW = $clog2(lock_count + 1);

    localparam logic [bit_count-1:0]      DEF_SPEED = bit_count'(default_speed);
    localparam logic signed [CLAMP_W-1:0] MIN_S     = CLAMP_W'(min_speed);
    localparam logic signed [CLAMP_W-1:0] MAX_S     = CLAMP_W'(max_speed);
    localparam logic signed [W-1:0]       KI_W      = W'(ki);
    localparam logic signed [W-1:0]       KP_W      = W'(kp);
    localparam logic [LRW-1:0]            LOCK_FULL = LRW'(lock_count);
    localparam logic [31:0]               THRESH    = 32'(lock_thresh);

    logic signed [AW-1:0] ws;
    logic                 win_end;

    logic [bit_count-1:0] integ_q, integ_d;
    logic [bit_count-1:0] speed_q, speed_d;
    logic                 strobe_q, strobe_d;
    logic [LRW-1:0]       lock_run_q, lock_run_d;
    logic                 locked_q, locked_d;

    logic signed [W-1:0]       ws_w, integ_sum, prop_w, speed_sum;
    logic signed [CLAMP_W-1:0] integ_c, speed_c;
    logic [AW-1:0]             abs_ws;
    logic                      quiet;

    bbpd_window_acc #(
        .decim (decim),
        .acc_w (AW)
    ) u_window_acc (
        .sys_clk    (sys_clk),
        .ext_rst    (ext_rst),
        .up_pulse   (up_pulse),
        .dn_pulse   (dn_pulse),
        .hold       (hold),
        .ws         (ws),
        .window_end (win_end)
    );

    always_comb begin
        ws_w      = {{(W - AW){ws[AW-1]}}, ws};
        integ_sum = {{(W - bit_count){1'b0}}, integ_q} + KI_W * ws_w;
        integ_c   = sat_clamp({{(CLAMP_W - W){integ_sum[W-1]}}, integ_sum}, MIN_S, MAX_S);

        if (ws[AW-1]) begin
            prop_w = -KP_W;
        end else if (ws != '0) begin
            prop_w = KP_W;
        end else begin
            prop_w = '0;
        end

        // Proportional kick rides on the already-clamped integrator value.
        speed_sum = {{(W - bit_count){1'b0}}, integ_c[bit_count-1:0]} + prop_w;
        speed_c   = sat_clamp({{(CLAMP_W - W){speed_sum[W-1]}}, speed_sum}, MIN_S, MAX_S);

        abs_ws = ws[AW-1] ? -ws : ws;
        quiet  = {{(32 - AW){1'b0}}, abs_ws} <= THRESH;
    end

    always_comb begin
        integ_d    = integ_q;
        speed_d    = speed_q;
        strobe_d   = win_end;
        lock_run_d = lock_run_q;
        locked_d   = locked_q;
        if (win_end) begin
            integ_d = integ_c[bit_count-1:0];
            speed_d = speed_c[bit_count-1:0];
            if (quiet) begin
                lock_run_d = (lock_run_q == LOCK_FULL) ? lock_run_q : lock_run_q + LRW'(1);
                locked_d   = locked_q | (lock_run_d == LOCK_FULL);
            end else begin
                lock_run_d = '0;
                locked_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (ext_rst) begin
            integ_q    <= DEF_SPEED;
            speed_q    <= DEF_SPEED;
            strobe_q   <= 1'b0;
            lock_run_q <= '0;
            locked_q   <= 1'b0;
        end else begin
            integ_q    <= integ_d;
            speed_q    <= speed_d;
            strobe_q   <= strobe_d;
            lock_run_q <= lock_run_d;
            locked_q   <= locked_d;
        end
    end

    assign speed_var     = speed_q;
    assign update_strobe = strobe_q;
    assign locked        = locked_q;

    // Clamp results are range-limited to the control word; upper bits are always zero.
    logic unused_clamp_bits;
    assign unused_clamp_bits = ^{integ_c[CLAMP_W-1:bit_count], speed_c[CLAMP_W-1:bit_count]};

endmodule

// File: tb/tb_pi_loop_filter.sv
module tb_pi_loop_filter;

    logic sys_clk = 1'b0;
    logic ext_rst = 1'b1;
    logic up_pulse = 1'b0;
    logic dn_pulse = 1'b0;
    logic hold = 1'b0;

    logic [23:0] spd_a, spd_b, spd_c;
    logic        stb_a, stb_b, stb_c;
    logic        lck_a, lck_b, lck_c;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 sys_clk = ~sys_clk;

    pi_loop_filter u_dut (
        .sys_clk       (sys_clk),
        .ext_rst       (ext_rst),
        .up_pulse      (up_pulse),
        .dn_pulse      (dn_pulse),
        .hold          (hold),
        .speed_var     (spd_a),
        .update_strobe (stb_a),
        .locked        (lck_a)
    );

    pi_loop_filter #(
        .default_speed (16777200),
        .ki            (4)
    ) u_dut_hi (
        .sys_clk       (sys_clk),
        .ext_rst       (ext_rst),
        .up_pulse      (up_pulse),
        .dn_pulse      (dn_pulse),
        .hold          (hold),
        .speed_var     (spd_b),
        .update_strobe (stb_b),
        .locked        (lck_b)
    );

    pi_loop_filter #(
        .default_speed (5),
        .min_speed     (0)
    ) u_dut_lo (
        .sys_clk       (sys_clk),
        .ext_rst       (ext_rst),
        .up_pulse      (up_pulse),
        .dn_pulse      (dn_pulse),
        .hold          (hold),
        .speed_var     (spd_c),
        .update_strobe (stb_c),
        .locked        (lck_c)
    );

    // Reference model: votes of the open window kept in a queue, resolved when it fills.
    int     win_q[$];
    longint m_integ[3];
    longint m_speed[3];
    longint m_def[3] = '{8388608, 16777200, 5};
    longint m_ki[3]  = '{1, 4, 1};
    int     m_lock_run = 0;
    bit     m_locked = 0;
    bit     m_strobe = 0;

    function automatic longint clampv(input longint v);
        if (v > 16777215) return 16777215;
        if (v < 0) return 0;
        return v;
    endfunction

    task automatic tick(input bit up, input bit dn, input bit hd, input bit rs);
        longint ws;
        longint prop;
        up_pulse = up;
        dn_pulse = dn;
        hold     = hd;
        ext_rst  = rs;
        @(posedge sys_clk);
        if (rs) begin
            win_q.delete();
            m_lock_run = 0;
            m_locked   = 0;
            m_strobe   = 0;
            for (int i = 0; i < 3; i++) begin
                m_integ[i] = m_def[i];
                m_speed[i] = m_def[i];
            end
        end else if (hd) begin
            win_q.delete();
            m_strobe = 0;
        end else begin
            win_q.push_back((up && !dn) ? 1 : ((dn && !up) ? -1 : 0));
            m_strobe = 0;
            if (win_q.size() == 16) begin
                ws = 0;
                foreach (win_q[k]) ws += win_q[k];
                prop = (ws > 0) ? 256 : ((ws < 0) ? -256 : 0);
                for (int i = 0; i < 3; i++) begin
                    m_integ[i] = clampv(m_integ[i] + m_ki[i] * ws);
                    m_speed[i] = clampv(m_integ[i] + prop);
                end
                if (ws <= 2 && ws >= -2) begin
                    if (m_lock_run < 8) m_lock_run++;
                    if (m_lock_run == 8) m_locked = 1;
                end else begin
                    m_lock_run = 0;
                    m_locked   = 0;
                end
                m_strobe = 1;
                win_q.delete();
            end
        end
        #1;
    endtask

    task automatic do_reset();
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 1);
    endtask

    task automatic test_reset();
        bit exp_stb;
        tick(1, 0, 1, 1);
        tick(1, 0, 0, 1);
        tick(0, 1, 0, 1);
        n_cmp++;
        if (spd_a !== 24'd8388608) begin
            n_bad++; $display("FAIL reset_speed: got %0d want %0d", spd_a, 8388608);
        end
        n_cmp++;
        if (lck_a !== 1'b0) begin
            n_bad++; $display("FAIL reset_locked: got %0b want 0", lck_a);
        end
        n_cmp++;
        if (stb_a !== 1'b0) begin
            n_bad++; $display("FAIL reset_strobe: got %0b want 0", stb_a);
        end
        n_cmp++;
        if (spd_c !== 24'd5) begin
            n_bad++; $display("FAIL reset_speed_lo: got %0d want 5", spd_c);
        end
        for (int c = 1; c <= 16; c++) begin
            tick(0, 0, 0, 0);
            exp_stb = (c == 16);
            n_cmp++;
            if (stb_a !== exp_stb) begin
                n_bad++; $display("FAIL first_strobe c=%0d: got %0b want %0b", c, stb_a, exp_stb);
            end
        end
    endtask

    task automatic test_constant_up();
        do_reset();
        for (int c = 0; c < 16; c++) tick(1, 0, 0, 0);
        n_cmp++;
        if (spd_a !== 24'd8388880) begin
            n_bad++; $display("FAIL up_window_speed: got %0d want %0d", spd_a, 8388880);
        end
        n_cmp++;
        if (stb_a !== 1'b1) begin
            n_bad++; $display("FAIL up_window_strobe: got %0b want 1", stb_a);
        end
        n_cmp++;
        if (spd_c !== 24'd277) begin
            n_bad++; $display("FAIL up_window_speed_lo: got %0d want 277", spd_c);
        end
        for (int c = 0; c < 16; c++) tick(0, 0, 0, 0);
        n_cmp++;
        if (spd_a !== 24'd8388624) begin
            n_bad++; $display("FAIL quiet_after_up: got %0d want %0d", spd_a, 8388624);
        end
    endtask

    task automatic test_lock();
        bit exp_lck;
        do_reset();
        for (int w = 0; w < 8; w++) begin
            for (int c = 0; c < 16; c++) tick(c % 2 == 0, c % 2 == 1, 0, 0);
            exp_lck = (w == 7);
            n_cmp++;
            if (lck_a !== exp_lck) begin
                n_bad++; $display("FAIL lock_rise w=%0d: got %0b want %0b", w, lck_a, exp_lck);
            end
            n_cmp++;
            if (spd_a !== 24'd8388608) begin
                n_bad++; $display("FAIL lock_speed w=%0d: got %0d want 8388608", w, spd_a);
            end
        end
        for (int c = 0; c < 16; c++) tick(0, 1, 0, 0);
        n_cmp++;
        if (lck_a !== 1'b0) begin
            n_bad++; $display("FAIL lock_drop: got %0b want 0", lck_a);
        end
        n_cmp++;
        if (spd_a !== 24'd8388336) begin
            n_bad++; $display("FAIL down_window_speed: got %0d want %0d", spd_a, 8388336);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int w = 0; w < 4; w++) begin
            for (int c = 0; c < 16; c++) begin
                tick(1, 0, 0, 0);
                n_cmp++;
                if (longint'(spd_b) != m_speed[1]) begin
                    n_bad++; $display("FAIL sat_hi_track: got %0d want %0d", spd_b, m_speed[1]);
                end
            end
            n_cmp++;
            if (spd_b !== 24'd16777215) begin
                n_bad++; $display("FAIL sat_hi w=%0d: got %0d want 16777215", w, spd_b);
            end
        end
        do_reset();
        for (int w = 0; w < 2; w++) begin
            for (int c = 0; c < 16; c++) tick(0, 1, 0, 0);
            n_cmp++;
            if (spd_c !== 24'd0) begin
                n_bad++; $display("FAIL sat_lo w=%0d: got %0d want 0", w, spd_c);
            end
        end
    endtask

    task automatic test_vote_11();
        do_reset();
        for (int c = 0; c < 16; c++) tick(1, 1, 0, 0);
        n_cmp++;
        if (stb_a !== 1'b1 || spd_a !== 24'd8388608) begin
            n_bad++; $display("FAIL vote_11: got stb=%0b spd=%0d want stb=1 spd=8388608",
                              stb_a, spd_a);
        end
    endtask

    task automatic test_hold();
        do_reset();
        for (int c = 0; c < 128; c++) tick(0, 0, 0, 0);
        for (int c = 0; c < 10; c++) tick(1, 0, 0, 0);
        for (int c = 0; c < 6; c++) begin
            tick(1, 0, 1, 0);
            n_cmp++;
            if (stb_a !== 1'b0 || spd_a !== 24'd8388608 || lck_a !== 1'b1) begin
                n_bad++; $display("FAIL hold c=%0d: got stb=%0b spd=%0d lck=%0b want 0/8388608/1",
                                  c, stb_a, spd_a, lck_a);
            end
        end
        for (int c = 1; c <= 16; c++) begin
            tick(0, 0, 0, 0);
            n_cmp++;
            if (stb_a !== (c == 16)) begin
                n_bad++; $display("FAIL hold_release c=%0d: got %0b want %0b", c, stb_a, c == 16);
            end
        end
        n_cmp++;
        if (spd_a !== 24'd8388608) begin
            n_bad++; $display("FAIL hold_discard: got %0d want 8388608", spd_a);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int c = 0; c < 128; c++) tick(0, 0, 0, 0);
        for (int c = 0; c < 12; c++) tick(1, 0, 0, 0);
        tick(1, 0, 1, 1);
        n_cmp++;
        if (lck_a !== 1'b0) begin
            n_bad++; $display("FAIL reset_mid_locked: got %0b want 0", lck_a);
        end
        for (int c = 0; c < 16; c++) tick(0, 0, 0, 0);
        n_cmp++;
        if (spd_a !== 24'd8388608 || stb_a !== 1'b1) begin
            n_bad++; $display("FAIL reset_mid_speed: got spd=%0d stb=%0b want 8388608/1",
                              spd_a, stb_a);
        end
    endtask

    task automatic test_random();
        int bias;
        bit up, dn, hd, rs;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if (c % 64 == 0) bias = $urandom_range(0, 3);
            case (bias)
                1: begin up = ($urandom_range(0, 9) < 8); dn = ($urandom_range(0, 9) < 1); end
                2: begin up = ($urandom_range(0, 9) < 1); dn = ($urandom_range(0, 9) < 8); end
                3: begin up = ($urandom_range(0, 19) == 0); dn = ($urandom_range(0, 19) == 0); end
                default: begin up = $urandom_range(0, 1); dn = $urandom_range(0, 1); end
            endcase
            hd = ($urandom_range(0, 29) == 0);
            rs = ($urandom_range(0, 499) == 0);
            tick(up, dn, hd, rs);
            n_cmp++;
            if (longint'(spd_a) != m_speed[0] || longint'(spd_b) != m_speed[1] ||
                longint'(spd_c) != m_speed[2]) begin
                n_bad++; $display("FAIL rand_speed c=%0d: got %0d/%0d/%0d want %0d/%0d/%0d", c,
                                  spd_a, spd_b, spd_c, m_speed[0], m_speed[1], m_speed[2]);
            end
            n_cmp++;
            if (stb_a !== m_strobe || stb_b !== m_strobe || stb_c !== m_strobe) begin
                n_bad++; $display("FAIL rand_strobe c=%0d: got %0b want %0b", c, stb_a, m_strobe);
            end
            n_cmp++;
            if (lck_a !== m_locked || lck_c !== m_locked) begin
                n_bad++; $display("FAIL rand_locked c=%0d: got %0b want %0b", c, lck_a, m_locked);
            end
        end
    endtask

    initial begin
        test_reset();
        test_constant_up();
        test_lock();
        test_saturation();
        test_vote_11();
        test_hold();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
